// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: arbitration mode constants and default bus width.
package bus_arbiter_pkg;
    localparam int ARB_FIXED      = 0;
    localparam int ARB_RR         = 1;
    localparam int DEFAULT_DATA_W = 16;
endpackage

// File: rtl/bus_arbiter_pick.sv
// bus_arb_pick: combinational picker, first set request at or after start, wrapping.
module bus_arb_pick #(
    parameter int N  = 6,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx
);
    always_comb begin
        idx = '0;
        // scan from the far end so the closest request to start is written last
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(start) + i) % N])
                idx = SW'((int'(start) + i) % N);
        gnt = (|req) ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: NUM_SRC producers with one-entry hold buffers arbitrated onto one
// registered shared bus, fixed-priority or round-robin.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = 6,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int SRC_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        i_valid,
    input  logic [NUM_SRC*DATA_W-1:0] i_data,
    output logic [NUM_SRC-1:0]        o_ready,
    input  logic                      i_stall,
    output logic                      o_bus_valid,
    output logic [DATA_W-1:0]         o_bus_data,
    output logic [SRC_W-1:0]          o_bus_src,
    output logic                      o_collision
);
    logic [NUM_SRC-1:0] hold_valid;
    logic [DATA_W-1:0]  hold_data [NUM_SRC];
    logic [SRC_W-1:0]   ptr;
    logic [NUM_SRC-1:0] accept, req, gnt;
    logic [SRC_W-1:0]   idx;
    logic [DATA_W-1:0]  word;
    logic               grant;

    assign o_ready = ~hold_valid;
    assign accept  = i_valid & o_ready;
    assign req     = hold_valid | accept;
    assign grant   = !i_stall && (|req);
    assign word    = hold_valid[idx] ? hold_data[idx] : i_data[idx*DATA_W +: DATA_W];

    bus_arb_pick #(.N(NUM_SRC), .SW(SRC_W)) u_pick (
        .req  (req),
        .start(ARB_MODE == ARB_RR ? ptr : '0),
        .gnt  (gnt),
        .idx  (idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid  <= '0;
            ptr         <= '0;
            o_bus_valid <= 1'b0;
            o_bus_data  <= '0;
            o_bus_src   <= '0;
            o_collision <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++)
                hold_data[k] <= '0;
        end else begin
            // every pending request except the winner ends up (or stays) held
            hold_valid <= grant ? (req & ~gnt) : req;
            for (int k = 0; k < NUM_SRC; k++)
                if (accept[k])
                    hold_data[k] <= i_data[k*DATA_W +: DATA_W];
            if (i_stall) begin
                o_collision <= 1'b0;
            end else begin
                o_bus_valid <= grant;
                o_bus_data  <= grant ? word : '0;
                o_bus_src   <= grant ? idx : o_bus_src;
                o_collision <= $countones(req) > 1;
                if (grant && ARB_MODE == ARB_RR)
                    ptr <= (idx == SRC_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule
